// File: rtl/tpu_dma_pkg.sv
// tpu_dma_pkg: shared state encoding, AXI constants and burst sizing for the writeback DMA.
package tpu_dma_pkg;

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} wb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Beats for the next burst: bounded by what is left, the burst cap and the next 4 KB page edge.
    function automatic logic [8:0] calc_burst(input logic [15:0] remaining, input logic [31:0] addr,
                                              input int max_burst, input int beat_bytes);
        int b;
        int edge_beats;
        edge_beats = (4096 - int'(addr[11:0])) / beat_bytes;
        b = int'(remaining);
        b = b > max_burst ? max_burst : b;
        b = b > edge_beats ? edge_beats : b;
        return 9'(b);
    endfunction

endpackage

// File: rtl/wb_beat_fifo.sv
// wb_beat_fifo: 2-entry beat FIFO between the buffer read port and the AXI W channel.
module wb_beat_fifo #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wp;
    logic                  rp;

    assign dout = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= 1'b0;
            rp    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/writeback_dma.sv
// writeback_dma: streams local buffer words to DDR as AXI4 INCR write bursts, one burst outstanding.
// Define WB_DMA_PERF_EN to add the perf_cycles / perf_stall counters.
module writeback_dma
    import tpu_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_pulse,
    input  logic [31:0]             dest_addr,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [15:0]             length,
    output logic                    done_irq,
    output logic                    busy,
    output logic                    err,
    output logic                    buf_rd_en,
    output logic [ADDR_WIDTH-1:0]   buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]   buf_rd_data,
    output logic [31:0]             m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
`ifdef WB_DMA_PERF_EN
    ,
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_stall
`endif
);

    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int LB         = $clog2(BEAT_BYTES);

    wb_state_e             state;
    logic [31:0]           dst;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [15:0]           remaining;
    logic [8:0]            burst;
    logic [8:0]            burst_c;
    logic [8:0]            rd_cnt;
    logic [8:0]            beat_cnt;
    logic                  rd_pending;
    logic [1:0]            fifo_count;
    logic                  pop;

    assign burst_c     = calc_burst(remaining, dst, MAX_BURST, BEAT_BYTES);
    assign m_awaddr    = dst;
    assign m_awlen     = 8'(burst_c - 9'd1);
    assign m_awsize    = 3'(LB);
    assign m_awburst   = AXI_BURST_INCR;
    assign m_wstrb     = '1;
    // Reads in flight count against FIFO space so a returning word always has a slot.
    assign buf_rd_en   = (state == S_W) && (rd_cnt < burst) && (({1'b0, fifo_count} + {2'b0, rd_pending}) < 3'd2);
    assign buf_rd_addr = rd_addr;
    assign m_wvalid    = fifo_count != 2'd0;
    assign m_wlast     = beat_cnt == burst - 9'd1;
    assign pop         = m_wvalid && m_wready;
    assign m_bready    = state == S_B;
    assign done_irq    = state == S_DONE;
    assign busy        = state != S_IDLE;

    wb_beat_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pending),
        .pop   (pop),
        .din   (buf_rd_data),
        .dout  (m_wdata),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dst        <= '0;
            rd_addr    <= '0;
            remaining  <= '0;
            burst      <= '0;
            rd_cnt     <= '0;
            beat_cnt   <= '0;
            rd_pending <= 1'b0;
            err        <= 1'b0;
            m_awvalid  <= 1'b0;
        end else begin
            rd_pending <= buf_rd_en;
            if (buf_rd_en) begin
                rd_addr <= rd_addr + 1'b1;
                rd_cnt  <= rd_cnt + 9'd1;
            end
            if (pop) beat_cnt <= beat_cnt + 9'd1;
            case (state)
                S_IDLE: if (start_pulse) begin
                    dst       <= dest_addr & ~32'(BEAT_BYTES - 1);
                    rd_addr   <= src_addr;
                    remaining <= length;
                    err       <= 1'b0;
                    m_awvalid <= length != 16'd0;
                    state     <= length == 16'd0 ? S_DONE : S_AW;
                end
                S_AW: if (m_awready) begin
                    m_awvalid <= 1'b0;
                    burst     <= burst_c;
                    remaining <= remaining - 16'(burst_c);
                    rd_cnt    <= '0;
                    beat_cnt  <= '0;
                    state     <= S_W;
                end
                S_W: if (pop && m_wlast) state <= S_B;
                S_B: if (m_bvalid) begin
                    if (m_bresp != AXI_RESP_OKAY) err <= 1'b1;
                    dst       <= dst + (32'(burst) << LB);
                    m_awvalid <= remaining != 16'd0;
                    state     <= remaining == 16'd0 ? S_DONE : S_AW;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_DMA_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == S_IDLE && start_pulse) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 32'd1;
            if (m_wvalid && !m_wready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_dma.sv
// tb_writeback_dma: directed bursts with a queued scoreboard checked by a negedge monitor.
module tb_writeback_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_pulse = 1'b0;
    logic [31:0] dest_addr = '0;
    logic [9:0]  src_addr = '0;
    logic [15:0] length = '0;
    logic        done_irq, busy, err, buf_rd_en;
    logic [9:0]  buf_rd_addr;
    logic [63:0] buf_rd_data = '0;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid, m_awready = 1'b0;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    logic        m_bvalid = 1'b0, m_bready;
`ifdef WB_DMA_PERF_EN
    logic [31:0] perf_cycles, perf_stall;
`endif

    always #5 clk = ~clk;

    writeback_dma dut (
        .clk(clk), .rst(rst), .start_pulse(start_pulse), .dest_addr(dest_addr), .src_addr(src_addr),
        .length(length), .done_irq(done_irq), .busy(busy), .err(err), .buf_rd_en(buf_rd_en),
        .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef WB_DMA_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    typedef struct {logic [31:0] addr; logic [7:0] len;} aw_t;
    aw_t         aw_q[$];
    logic [64:0] w_q[$];
    logic [1:0]  bresp_q[$];
    aw_t         ae;
    logic [64:0] we;
    int errors = 0, checks = 0;
    int done_exp = 0, done_cnt = 0, rd_cnt = 0, w_hs = 0, b_owed = 0;
    int aw_delay = 1, aw_cnt = 0, stall_pct = 0;
    bit aw_hs_f = 0, b_hs_f = 0, prev_wstall = 0;
    logic [63:0] prev_wdata;
    logic [9:0]  rd_exp = '0;

    function automatic logic [63:0] pat(int a);
        return {32'hC0DE_0000 + 32'(a), 32'hFFFF_FFFF - 32'(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) if (buf_rd_en) buf_rd_data <= pat(int'(buf_rd_addr));

    // Monitor: sees values that hold through the next rising edge, so a seen handshake happens there.
    always @(negedge clk) begin
        if (rst) prev_wstall = 0;
        else begin
            if (buf_rd_en) begin
                chk("rd_addr", 64'(buf_rd_addr), 64'(rd_exp));
                rd_exp++;
                rd_cnt++;
            end
            if (prev_wstall) begin
                chk("wvalid_hold", 64'(m_wvalid), 64'd1);
                chk("wdata_hold", m_wdata, prev_wdata);
            end
            prev_wstall = m_wvalid && !m_wready;
            prev_wdata  = m_wdata;
            if (m_awvalid && m_awready) begin
                aw_hs_f = 1;
                chk("aw_expected", 64'(aw_q.size() > 0), 64'd1);
                if (aw_q.size() > 0) begin
                    ae = aw_q.pop_front();
                    chk("awaddr", 64'(m_awaddr), 64'(ae.addr));
                    chk("awlen", 64'(m_awlen), 64'(ae.len));
                    chk("awsize", 64'(m_awsize), 64'd3);
                    chk("awburst", 64'(m_awburst), 64'd1);
                end
            end
            if (m_wvalid && m_wready) begin
                w_hs++;
                chk("w_expected", 64'(w_q.size() > 0), 64'd1);
                if (w_q.size() > 0) begin
                    we = w_q.pop_front();
                    chk("wdata", m_wdata, we[63:0]);
                    chk("wlast", 64'(m_wlast), 64'(we[64]));
                    chk("wstrb", 64'(m_wstrb), 64'hFF);
                end
                if (m_wlast) b_owed++;
            end
            if (m_bvalid && m_bready) b_hs_f = 1;
            if (done_irq) begin
                chk("done_expected", 64'(done_exp > 0), 64'd1);
                if (done_exp > 0) done_exp--;
                done_cnt++;
                chk("aw_drained", 64'(aw_q.size()), 64'd0);
                chk("w_drained", 64'(w_q.size()), 64'd0);
            end
        end
    end

    // Slave-side drivers, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            m_bvalid = 0; m_awready = 0; m_wready = 0;
            b_owed = 0; b_hs_f = 0; aw_hs_f = 0; aw_cnt = 0;
        end else begin
            if (b_hs_f) begin m_bvalid = 0; b_hs_f = 0; end
            if (!m_bvalid && b_owed > 0) begin
                m_bvalid = 1;
                m_bresp = bresp_q.size() > 0 ? bresp_q.pop_front() : 2'b00;
                b_owed--;
            end
            if (aw_hs_f) begin aw_cnt = 0; aw_hs_f = 0; end
            else if (m_awvalid) aw_cnt++;
            m_awready = m_awvalid && aw_cnt >= aw_delay;
            m_wready = $urandom_range(0, 99) >= stall_pct;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic start(input logic [31:0] d, input logic [9:0] s, input logic [15:0] l);
        start_pulse = 1; dest_addr = d; src_addr = s; length = l;
        tick();
        start_pulse = 0;
    endtask

    task automatic exp_burst(input logic [31:0] a, input int beats, input int s);
        aw_q.push_back('{a, 8'(beats - 1)});
        for (int i = 0; i < beats; i++) w_q.push_back({i == beats - 1, pat((s + i) % 1024)});
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_exp > 0 && n < 5000) begin tick(); n++; end
        chk("done_seen", 64'(done_exp), 64'd0);
        done_exp = 0;
        tick();
    endtask

    task automatic run(input logic [31:0] d, input logic [9:0] s, input logic [15:0] l);
        rd_exp = s; rd_cnt = 0; done_exp++;
        start(d, s, l);
        wait_done();
        chk("rd_count", 64'(rd_cnt), 64'(l));
    endtask

    initial begin
        int n;
        tick(3);
        chk("rst_awvalid", 64'(m_awvalid), 0);
        chk("rst_wvalid", 64'(m_wvalid), 0);
        chk("rst_bready", 64'(m_bready), 0);
        chk("rst_rd_en", 64'(buf_rd_en), 0);
        chk("rst_busy_done_err", 64'({busy, done_irq, err}), 0);
        rst = 0;
        tick(2);
        exp_burst(32'h1000, 5, 16);
        run(32'h1000, 10'd16, 16'd5);
        exp_burst(32'h0, 16, 256); exp_burst(32'h80, 16, 272); exp_burst(32'h100, 8, 288);
        run(32'h0, 10'd256, 16'd40);
        exp_burst(32'hFE0, 4, 512); exp_burst(32'h1000, 6, 516);
        run(32'hFE0, 10'd512, 16'd10);
        aw_delay = 3; stall_pct = 30;
        exp_burst(32'h2000, 16, 600); exp_burst(32'h2080, 4, 616);
        run(32'h2000, 10'd600, 16'd20);
        aw_delay = 1; stall_pct = 0;
        bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
        exp_burst(32'h3000, 16, 700); exp_burst(32'h3080, 4, 716);
        run(32'h3000, 10'd700, 16'd20);
        chk("err_set", 64'(err), 1);
        chk("idle_after_done", 64'(busy), 0);
        rd_cnt = 0; done_exp++;
        start(32'h5555, 10'd5, 16'd0);
        chk("err_cleared", 64'(err), 0);
        chk("busy_len0", 64'(busy), 1);
        wait_done();
        chk("rd_count_len0", 64'(rd_cnt), 0);
        aw_delay = 4;
        exp_burst(32'h4000, 3, 64);
        rd_exp = 10'd64; rd_cnt = 0; done_exp++;
        start(32'h4005, 10'd64, 16'd3);
        start(32'h5000, 10'd128, 16'd7);
        wait_done();
        chk("rd_count_ignore", 64'(rd_cnt), 3);
        aw_delay = 1;
        exp_burst(32'h6000, 16, 0);
        rd_exp = 0; w_hs = 0; n = 0;
        start(32'h6000, 10'd0, 16'd16);
        while (w_hs == 0 && n < 200) begin tick(); n++; end
        chk("w_started", 64'(w_hs > 0), 1);
        n = done_cnt;
        rst = 1;
        tick();
        rst = 0;
        aw_q.delete(); w_q.delete(); bresp_q.delete();
        chk("abort_valids", 64'({m_awvalid, m_wvalid, buf_rd_en, m_bready}), 0);
        chk("abort_busy_done", 64'({busy, done_irq}), 0);
        tick(20);
        chk("abort_quiet", 64'({m_awvalid, m_wvalid, buf_rd_en, busy}), 0);
        chk("abort_no_done", 64'(done_cnt), 64'(n));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
